sysreg_intr_ctrl: RTL and testbench
===================================

Name: sysreg_intr_ctrl

Overview:
- Sequences the BotSim → KCPSM6 system-register path.
- On each upd_sysregs pulse it freezes a coherent snapshot of LocX/LocY/Sensors/botInfo/lmdist/rmdist and raises the KCPSM6 interrupt. It holds the interrupt until interrupt_ack, keeps the snapshot stable until firmware signals service done, then enforces a hold-off.
- Sits between BotSim and BotInterface. It replaces ad-hoc interrupt generation and counts missed (overrun) and unacknowledged (timeout) updates.

Parameters:
- ACK_TIMEOUT, 50000, cycles in PEND without interrupt_ack before the interrupt is abandoned; must be ≥1.
- HOLDOFF_CYCLES, 4, minimum cycles between svc_done and the next interrupt; 0 allowed.
- TMR_W, 16, width of the shared timeout/hold-off timer; must hold max(ACK_TIMEOUT, HOLDOFF_CYCLES).

Ports:
- clk  in  1  system clock (sysclk, 75 MHz)
- reset  in  1  synchronous, active-low reset
- enable  in  1  1 = interrupts allowed (debounced switch)
- upd_sysregs  in  1  BotSim single-cycle update pulse
- LocX, LocY, Sensors, botInfo, lmdist, rmdist  in  8 each  live BotSim registers
- interrupt  out  1  to KCPSM6, registered
- interrupt_ack  in  1  from KCPSM6
- svc_done  in  1  decoded firmware write: snapshot consumed
- cnt_clr  in  1  clears both counters
- snap_LocX, snap_LocY, snap_Sensors, snap_botInfo, snap_lmdist, snap_rmdist  out  8 each  frozen snapshot to BotInterface read mux
- overrun_cnt  out  8  saturating count of overwritten pending updates
- timeout_cnt  out  8  saturating count of ACK timeouts
- state_o  out  2  current state encoding, for debug/LEDs

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; interrupt=0; all snap_* and staging registers=0; pend=0; counters=0; timer=0.
- States are IDLE=0, PEND=1, SVC=2, HOLD=3. state_o is the registered state.
- IDLE:
  - upd_sysregs & enable → snap_* <= live inputs, state→PEND, timer<=0. interrupt goes 1 at the same edge (1-cycle latency from the sampled upd).
  - Otherwise, pend & enable → snap_* <= staging, pend<=0, →PEND.
- PEND:
  - interrupt=1.
  - interrupt_ack → interrupt<=0, →SVC.
  - Otherwise timer++. When timer reaches ACK_TIMEOUT-1 without ack: interrupt<=0, timeout_cnt++ (saturating), →IDLE. Snapshot is left unchanged.
  - ack on the final timeout cycle: ack wins, no timeout counted.
- SVC:
  - interrupt=0; snap_* frozen.
  - svc_done → timer<=0, then →HOLD, or →IDLE directly if HOLDOFF_CYCLES==0.
- HOLD:
  - timer++ until timer==HOLDOFF_CYCLES-1, then →IDLE.
- Updates outside IDLE-accept (states PEND/SVC/HOLD, or IDLE with enable=1 but an accept in progress):
  - upd_sysregs → staging <= live inputs, pend<=1.
  - If pend was already 1, overrun_cnt++ (saturating) and staging is overwritten: newest wins.
- snap_* changes only on PEND entry; it never changes in PEND, SVC or HOLD.
- enable=0:
  - upd_sysregs is ignored entirely (no staging, no counting); pend<=0.
  - A PEND/SVC/HOLD sequence already in progress completes normally.
- interrupt_ack outside PEND and svc_done outside SVC are ignored.
- upd_sysregs and svc_done in the same SVC cycle: both take effect (pend set, →HOLD).
- Counters:
  - Stick at 255.
  - cnt_clr zeroes both and has priority over an increment in the same cycle.
- Reset mid-operation (any state) returns everything to reset values on that edge; the interrupt drops the next cycle.
- No combinational paths from inputs to outputs.

Decomposition:
- Package sysreg_intr_pkg:
  - state encoding localparams (IDLE/PEND/SVC/HOLD)
  - default ACK_TIMEOUT and HOLDOFF_CYCLES
  - the 6-register snapshot bundle width (48)
- One sub-module, sat_counter8: 8-bit saturating counter with inc, clr (priority) and sync active-low reset. Instantiated twice (overrun, timeout).

Test Plan:
1. Reset held, then released; pulse upd with LocX=0x12, LocY=0x34 → interrupt=1 the cycle after; snap_LocX=0x12, snap_LocY=0x34; state_o=1.
2. In PEND, ack after 3 cycles → interrupt=0 next cycle, state_o=2. Change live LocX to 0x99 → snap_LocX stays 0x12. Pulse svc_done → HOLD for 4 cycles, then IDLE.
3. Two upd pulses during SVC (LocX=0x21, then 0x22) → overrun_cnt=1. After HOLD, interrupt re-asserts with snap_LocX=0x22.
4. ACK_TIMEOUT=8, no ack → interrupt high exactly 8 cycles then 0, timeout_cnt=1, state_o=0. Ack on the 8th cycle instead → state_o=2, timeout_cnt unchanged.
5. enable=0, pulse upd → no interrupt, overrun_cnt unchanged. Force 300 overruns → overrun_cnt=255. cnt_clr concurrent with an overrun → 0.
6. Assert reset in SVC and in PEND → interrupt=0, snap_*=0, counters=0, state_o=0 the next cycle.

Source files
------------

// File: rtl/sysreg_intr_pkg.sv
// Shared state encoding, default timing and snapshot bundle for the BotSim -> KCPSM6 register path.
package sysreg_intr_pkg;

    localparam logic [1:0] IDLE_ENC = 2'd0;
    localparam logic [1:0] PEND_ENC = 2'd1;
    localparam logic [1:0] SVC_ENC  = 2'd2;
    localparam logic [1:0] HOLD_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE_ENC,
        ST_PEND = PEND_ENC,
        ST_SVC  = SVC_ENC,
        ST_HOLD = HOLD_ENC
    } state_e;

    localparam int DEF_ACK_TIMEOUT    = 50000;
    localparam int DEF_HOLDOFF_CYCLES = 4;
    localparam int SNAP_W             = 48;

    typedef struct packed {
        logic [7:0] loc_x;
        logic [7:0] loc_y;
        logic [7:0] sensors;
        logic [7:0] bot_info;
        logic [7:0] lmdist;
        logic [7:0] rmdist;
    } snap_t;

endpackage

// File: rtl/sysreg_intr_ctrl_sat_counter8.sv
// 8-bit event counter that sticks at 255; clear beats increment.
module sat_counter8 (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [7:0] cnt_o
);
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/sysreg_intr_ctrl.sv
// Freezes a coherent register snapshot per BotSim update and drives the KCPSM6 interrupt handshake.
// Updates arriving mid-service are staged (newest wins); ack timeouts and overruns are counted.
module sysreg_intr_ctrl
    import sysreg_intr_pkg::*;
#(
    parameter int ACK_TIMEOUT    = DEF_ACK_TIMEOUT,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int TMR_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       upd_sysregs,
    input  logic [7:0] LocX,
    input  logic [7:0] LocY,
    input  logic [7:0] Sensors,
    input  logic [7:0] botInfo,
    input  logic [7:0] lmdist,
    input  logic [7:0] rmdist,
    output logic       interrupt,
    input  logic       interrupt_ack,
    input  logic       svc_done,
    input  logic       cnt_clr,
    output logic [7:0] snap_LocX,
    output logic [7:0] snap_LocY,
    output logic [7:0] snap_Sensors,
    output logic [7:0] snap_botInfo,
    output logic [7:0] snap_lmdist,
    output logic [7:0] snap_rmdist,
    output logic [7:0] overrun_cnt,
    output logic [7:0] timeout_cnt,
    output logic [1:0] state_o
);
    localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    state_e           state_q, state_d;
    logic             intr_q, intr_d;
    logic             pend_q, pend_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    snap_t            snap_q, snap_d;
    snap_t            stage_q, stage_d;
    snap_t            live;
    logic             ovr_inc, tmo_inc;

    assign live = '{loc_x: LocX, loc_y: LocY, sensors: Sensors,
                    bot_info: botInfo, lmdist: lmdist, rmdist: rmdist};

    always_comb begin
        state_d = state_q;
        intr_d  = intr_q;
        pend_d  = pend_q;
        timer_d = timer_q;
        snap_d  = snap_q;
        stage_d = stage_q;
        ovr_inc = 1'b0;
        tmo_inc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A fresh update supersedes anything still staged.
                if (enable && upd_sysregs) begin
                    snap_d  = live;
                    pend_d  = 1'b0;
                    ovr_inc = pend_q;
                    timer_d = '0;
                    intr_d  = 1'b1;
                    state_d = ST_PEND;
                end else if (enable && pend_q) begin
                    snap_d  = stage_q;
                    pend_d  = 1'b0;
                    timer_d = '0;
                    intr_d  = 1'b1;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (interrupt_ack) begin
                    intr_d  = 1'b0;
                    state_d = ST_SVC;
                end else if (timer_q == ACK_LAST) begin
                    intr_d  = 1'b0;
                    tmo_inc = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_SVC: begin
                intr_d = 1'b0;
                if (svc_done) begin
                    timer_d = '0;
                    if (HOLDOFF_CYCLES == 0) state_d = ST_IDLE;
                    else                     state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (timer_q == HOLD_LAST) state_d = ST_IDLE;
                else                      timer_d = timer_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && enable && upd_sysregs) begin
            stage_d = live;
            pend_d  = 1'b1;
            ovr_inc = pend_q;
        end

        if (!enable) pend_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            intr_q  <= 1'b0;
            pend_q  <= 1'b0;
            timer_q <= '0;
            snap_q  <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            intr_q  <= intr_d;
            pend_q  <= pend_d;
            timer_q <= timer_d;
            snap_q  <= snap_d;
            stage_q <= stage_d;
        end
    end

    sat_counter8 u_overrun_cnt (
        .clk_i   (clk),
        .rst_n_i (reset),
        .clr_i   (cnt_clr),
        .inc_i   (ovr_inc),
        .cnt_o   (overrun_cnt)
    );

    sat_counter8 u_timeout_cnt (
        .clk_i   (clk),
        .rst_n_i (reset),
        .clr_i   (cnt_clr),
        .inc_i   (tmo_inc),
        .cnt_o   (timeout_cnt)
    );

    assign interrupt    = intr_q;
    assign state_o      = state_q;
    assign snap_LocX    = snap_q.loc_x;
    assign snap_LocY    = snap_q.loc_y;
    assign snap_Sensors = snap_q.sensors;
    assign snap_botInfo = snap_q.bot_info;
    assign snap_lmdist  = snap_q.lmdist;
    assign snap_rmdist  = snap_q.rmdist;
endmodule

// File: tb/tb_sysreg_intr_ctrl.sv
// Directed bench for sysreg_intr_ctrl: timed expectations plus a per-interrupt snapshot scoreboard.
module tb_sysreg_intr_ctrl;

    localparam int S_INTR = 0, S_STATE = 1, S_LOCX = 2, S_OVR = 3, S_TMO = 4, S_SNAP = 5;

    logic       clk = 1'b0;
    logic       reset, enable, upd_sysregs, interrupt_ack, svc_done, cnt_clr;
    logic [7:0] LocX, LocY, Sensors, botInfo, lmdist, rmdist;
    logic       interrupt;
    logic [7:0] snap_LocX, snap_LocY, snap_Sensors, snap_botInfo, snap_lmdist, snap_rmdist;
    logic [7:0] overrun_cnt, timeout_cnt;
    logic [1:0] state_o;

    typedef struct {
        int          at;
        int          sel;
        logic [47:0] val;
    } exp_t;

    exp_t        expq[$];
    logic [47:0] snapq[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic        intr_prev = 1'b0;

    sysreg_intr_ctrl #(.ACK_TIMEOUT(8), .HOLDOFF_CYCLES(4), .TMR_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .upd_sysregs(upd_sysregs),
        .LocX(LocX), .LocY(LocY), .Sensors(Sensors), .botInfo(botInfo),
        .lmdist(lmdist), .rmdist(rmdist),
        .interrupt(interrupt), .interrupt_ack(interrupt_ack), .svc_done(svc_done),
        .cnt_clr(cnt_clr),
        .snap_LocX(snap_LocX), .snap_LocY(snap_LocY), .snap_Sensors(snap_Sensors),
        .snap_botInfo(snap_botInfo), .snap_lmdist(snap_lmdist), .snap_rmdist(snap_rmdist),
        .overrun_cnt(overrun_cnt), .timeout_cnt(timeout_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [47:0] observe(input int sel);
        case (sel)
            S_INTR:  return {47'd0, interrupt};
            S_STATE: return {46'd0, state_o};
            S_LOCX:  return {40'd0, snap_LocX};
            S_OVR:   return {40'd0, overrun_cnt};
            S_TMO:   return {40'd0, timeout_cnt};
            default: return {snap_LocX, snap_LocY, snap_Sensors, snap_botInfo, snap_lmdist, snap_rmdist};
        endcase
    endfunction

    function automatic string sel_name(input int sel);
        case (sel)
            S_INTR:  return "interrupt";
            S_STATE: return "state_o";
            S_LOCX:  return "snap_LocX";
            S_OVR:   return "overrun_cnt";
            S_TMO:   return "timeout_cnt";
            default: return "snap_all";
        endcase
    endfunction

    // Monitor: timed expectations fire on their cycle; each interrupt rise consumes one snapshot.
    always @(negedge clk) begin
        logic [47:0] got;
        logic [47:0] want;
        for (int i = expq.size() - 1; i >= 0; i--) begin
            if (expq[i].at == cyc) begin
                got = observe(expq[i].sel);
                checks++;
                if (got !== expq[i].val) begin
                    failures++;
                    $display("FAIL %s cycle %0d: got %0h expected %0h",
                             sel_name(expq[i].sel), cyc, got, expq[i].val);
                end
                expq.delete(i);
            end
        end
        if (interrupt === 1'b1 && intr_prev !== 1'b1) begin
            checks++;
            got = observe(S_SNAP);
            if (snapq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_interrupt cycle %0d: got snapshot %0h expected no interrupt", cyc, got);
            end else begin
                want = snapq.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL irq_snapshot cycle %0d: got %0h expected %0h", cyc, got, want);
                end
            end
        end
        intr_prev = interrupt;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_at(input int d, input int sel, input logic [47:0] val);
        exp_t e;
        e.at  = cyc + d;
        e.sel = sel;
        e.val = val;
        expq.push_back(e);
    endtask

    task automatic push_snap();
        snapq.push_back({LocX, LocY, Sensors, botInfo, lmdist, rmdist});
    endtask

    task automatic expect_reset_values();
        expect_at(1, S_INTR, 0);
        expect_at(1, S_STATE, 0);
        expect_at(1, S_SNAP, 0);
        expect_at(1, S_OVR, 0);
        expect_at(1, S_TMO, 0);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; upd_sysregs = 1'b0; interrupt_ack = 1'b0;
        svc_done = 1'b0; cnt_clr = 1'b0;
        LocX = 8'h00; LocY = 8'h00; Sensors = 8'hA5; botInfo = 8'h3C; lmdist = 8'h07; rmdist = 8'hF0;
        repeat (2) tick();
        expect_reset_values();
        tick();
        reset = 1'b1;
        tick();

        // Update accepted in IDLE: interrupt one cycle later with the live values frozen.
        LocX = 8'h12; LocY = 8'h34; upd_sysregs = 1'b1;
        push_snap();
        expect_at(1, S_INTR, 1);
        expect_at(1, S_STATE, 1);
        tick();
        upd_sysregs = 1'b0;
        expect_at(1, S_INTR, 1);
        expect_at(2, S_INTR, 1);
        repeat (2) tick();
        interrupt_ack = 1'b1;
        expect_at(1, S_INTR, 0);
        expect_at(1, S_STATE, 2);
        tick();
        interrupt_ack = 1'b0;
        LocX = 8'h99;
        expect_at(1, S_LOCX, 8'h12);
        tick();

        // Two updates during service: one overrun, newest staged value wins.
        LocX = 8'h21; upd_sysregs = 1'b1;
        tick();
        upd_sysregs = 1'b0;
        tick();
        LocX = 8'h22; upd_sysregs = 1'b1;
        expect_at(1, S_OVR, 1);
        expect_at(1, S_LOCX, 8'h12);
        tick();
        upd_sysregs = 1'b0;
        svc_done = 1'b1;
        push_snap();
        for (int d = 1; d <= 4; d++) expect_at(d, S_STATE, 3);
        expect_at(5, S_STATE, 0);
        expect_at(6, S_STATE, 1);
        expect_at(6, S_INTR, 1);
        expect_at(6, S_LOCX, 8'h22);
        tick();
        svc_done = 1'b0;
        repeat (5) tick();

        // No ack: interrupt held exactly ACK_TIMEOUT cycles, then abandoned.
        for (int d = 1; d <= 7; d++) expect_at(d, S_INTR, 1);
        expect_at(8, S_INTR, 0);
        expect_at(8, S_STATE, 0);
        expect_at(8, S_TMO, 1);
        expect_at(8, S_LOCX, 8'h22);
        repeat (8) tick();

        // Ack on the final timeout cycle wins.
        LocX = 8'h40; upd_sysregs = 1'b1;
        push_snap();
        tick();
        upd_sysregs = 1'b0;
        for (int d = 1; d <= 7; d++) expect_at(d, S_INTR, 1);
        repeat (7) tick();
        interrupt_ack = 1'b1;
        expect_at(1, S_STATE, 2);
        expect_at(1, S_INTR, 0);
        expect_at(1, S_TMO, 1);
        tick();
        interrupt_ack = 1'b0;
        svc_done = 1'b1;
        expect_at(4, S_STATE, 3);
        expect_at(5, S_STATE, 0);
        tick();
        svc_done = 1'b0;
        repeat (4) tick();

        // Disabled: update ignored entirely.
        enable = 1'b0; LocX = 8'h55; upd_sysregs = 1'b1;
        for (int d = 1; d <= 3; d++) begin
            expect_at(d, S_INTR, 0);
            expect_at(d, S_STATE, 0);
        end
        expect_at(3, S_OVR, 1);
        tick();
        upd_sysregs = 1'b0;
        repeat (2) tick();
        enable = 1'b1;

        // Saturation: park in SVC and stream updates.
        LocX = 8'h60; upd_sysregs = 1'b1;
        push_snap();
        expect_at(1, S_STATE, 1);
        tick();
        upd_sysregs = 1'b0; interrupt_ack = 1'b1;
        expect_at(1, S_STATE, 2);
        tick();
        interrupt_ack = 1'b0; upd_sysregs = 1'b1;
        repeat (301) tick();
        expect_at(0, S_OVR, 255);
        expect_at(0, S_LOCX, 8'h60);
        cnt_clr = 1'b1;
        expect_at(1, S_OVR, 0);
        expect_at(1, S_TMO, 0);
        tick();
        cnt_clr = 1'b0;
        expect_at(1, S_OVR, 1);
        tick();
        upd_sysregs = 1'b0;

        // Reset while in SVC.
        reset = 1'b0;
        expect_reset_values();
        tick();
        reset = 1'b1;
        tick();

        // Reset while in PEND with a nonzero overrun count.
        LocX = 8'h70; upd_sysregs = 1'b1;
        push_snap();
        repeat (3) tick();
        upd_sysregs = 1'b0;
        expect_at(0, S_OVR, 1);
        expect_at(0, S_INTR, 1);
        reset = 1'b0;
        expect_reset_values();
        tick();
        reset = 1'b1;
        repeat (3) tick();

        checks++;
        if (expq.size() != 0 || snapq.size() != 0) begin
            failures++;
            $display("FAIL leftover_expectations: got %0d timed and %0d snapshots pending, expected 0 and 0",
                     expq.size(), snapq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
